// File: rtl/rs_pe_1d.sv
// rs_pe_1d: row-stationary PE with weight scratchpad, sliding window, one time-multiplexed MAC and saturated psum output
module rs_pe_1d #(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int FILT_LEN = 3,
  parameter int ACC_W    = 2 * DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     w_reload,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic signed [DATA_W-1:0] if_data,
  input  logic                     if_last,
  input  logic                     psum_in_valid,
  output logic                     psum_in_ready,
  input  logic signed [DATA_W-1:0] psum_in,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic signed [DATA_W-1:0] psum_out,
  output logic                     sat_pulse,
  output logic                     row_err
);
  localparam int IW = $clog2(FILT_LEN);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [IW-1:0] LAST = IW'(FILT_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(FILT_LEN);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({(DATA_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  typedef enum logic [1:0] {LOAD_W, FILL, MAC, OUT} state_t;
  state_t state;
  logic [IW-1:0] w_idx, k;
  logic [CW-1:0] win_cnt, cnt_nxt;
  logic signed [DATA_W-1:0] wspad [FILT_LEN];
  logic signed [DATA_W-1:0] win [FILT_LEN];
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [2*DATA_W-1:0] prod;
  logic row_end, reload_go;
  always_comb begin
    reload_go     = state == FILL && w_reload && win_cnt == '0 && !psum_out_valid;
    w_ready       = state == LOAD_W;
    if_ready      = state == FILL && !reload_go;
    psum_in_ready = state == OUT && (!psum_out_valid || psum_out_ready);
    cnt_nxt       = win_cnt == FULL ? FULL : win_cnt + 1'b1;
    prod          = (2*DATA_W)'(win[k]) * (2*DATA_W)'(wspad[k]);
    sum           = acc + ACC_W'(psum_in);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD_W;
      w_idx          <= '0;
      k              <= '0;
      win_cnt        <= '0;
      acc            <= '0;
      row_end        <= 1'b0;
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
      sat_pulse      <= 1'b0;
      row_err        <= 1'b0;
    end else begin
      sat_pulse <= 1'b0;
      row_err   <= 1'b0;
      if (psum_out_valid && psum_out_ready) psum_out_valid <= 1'b0;
      case (state)
        LOAD_W: if (w_valid) begin
          wspad[w_idx] <= w_data;
          w_idx        <= w_idx == LAST ? '0 : w_idx + 1'b1;
          if (w_idx == LAST) state <= FILL;
        end
        FILL: if (reload_go) state <= LOAD_W;
        else if (if_valid) begin
          for (int i = 0; i < FILT_LEN - 1; i++) win[i] <= win[i+1];
          win[FILT_LEN-1] <= if_data;
          if (cnt_nxt == FULL) begin
            win_cnt <= FULL;
            acc     <= '0;
            k       <= '0;
            row_end <= if_last;
            state   <= MAC;
          end else if (if_last) begin
            row_err <= 1'b1;
            win_cnt <= '0;
          end else win_cnt <= cnt_nxt;
        end
        MAC: begin
          acc <= acc + ACC_W'(prod >>> FRAC_W);
          k   <= k + 1'b1;
          if (k == LAST) state <= OUT;
        end
        OUT: if (psum_in_valid && psum_in_ready) begin
          psum_out       <= sum > MAX_V ? MAX_V[DATA_W-1:0] : sum < MIN_V ? MIN_V[DATA_W-1:0] : sum[DATA_W-1:0];
          psum_out_valid <= 1'b1;
          sat_pulse      <= sum > MAX_V || sum < MIN_V;
          win_cnt        <= row_end ? '0 : FULL - 1'b1;
          state          <= FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rs_pe_1d.sv
// tb_rs_pe_1d: directed self-checking bench for rs_pe_1d with FILT_LEN=3, Q7.8
module tb_rs_pe_1d;
  logic clk = 1'b0, rst = 1'b1;
  logic w_valid = 1'b0, w_reload = 1'b0, if_valid = 1'b0, if_last = 1'b0;
  logic psum_in_valid = 1'b1, psum_out_ready = 1'b1;
  logic signed [15:0] w_data = '0, if_data = '0, psum_in = '0;
  logic w_ready, if_ready, psum_in_ready, psum_out_valid, sat_pulse, row_err;
  logic signed [15:0] psum_out;
  logic signed [15:0] v;
  logic s, ok;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  rs_pe_1d dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_reload(w_reload),
    .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data), .if_last(if_last),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in(psum_in),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out(psum_out),
    .sat_pulse(sat_pulse), .row_err(row_err)
  );
  task automatic send_w(input logic signed [15:0] d);
    int n = 0;
    w_valid = 1'b1;
    w_data = d;
    while (!w_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!w_ready) begin failures++; $display("FAIL w_handshake: w_ready=%0b required 1", w_ready); end
    @(negedge clk);
    w_valid = 1'b0;
  endtask
  task automatic send_px(input logic signed [15:0] d, input logic last);
    int n = 0;
    if_valid = 1'b1;
    if_data = d;
    if_last = last;
    while (!if_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!if_ready) begin failures++; $display("FAIL if_handshake: if_ready=%0b required 1", if_ready); end
    @(negedge clk);
    if_valid = 1'b0;
    if_last = 1'b0;
  endtask
  task automatic load_w(input logic signed [15:0] a, b, c, input logic reload);
    int n = 0;
    if (reload) begin
      w_reload = 1'b1;
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      w_reload = 1'b0;
      checks++;
      if (!w_ready || if_ready) begin
        failures++;
        $display("FAIL reload: w_ready=%0b if_ready=%0b required 1 0", w_ready, if_ready);
      end
    end
    send_w(a);
    send_w(b);
    send_w(c);
  endtask
  task automatic wait_out(output logic signed [15:0] val, output logic sat, output logic got);
    int n = 0;
    while (!psum_out_valid && n < 50) begin @(negedge clk); n++; end
    got = psum_out_valid;
    val = psum_out;
    sat = sat_pulse;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({w_ready, if_ready, psum_in_ready, psum_out_valid, sat_pulse, row_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 100000", {w_ready, if_ready, psum_in_ready, psum_out_valid, sat_pulse, row_err});
    end
    checks++;
    if (psum_out !== 16'sd0) begin failures++; $display("FAIL reset_psum: got %0d required 0", psum_out); end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    load_w(16'sd256, 16'sd512, -16'sd256, 1'b0);
    psum_in = 16'sd0;
    send_px(16'sd256, 1'b0);
    send_px(16'sd512, 1'b0);
    send_px(16'sd768, 1'b0);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd512 || s !== 1'b0) begin failures++; $display("FAIL basic_w0: got %0d sat %0b valid %0b required 512 sat 0", v, s, ok); end
    send_px(16'sd1024, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd1024 || s !== 1'b0) begin failures++; $display("FAIL basic_w1: got %0d sat %0b valid %0b required 1024 sat 0", v, s, ok); end
    checks++;
    if (dut.win_cnt !== 2'd0) begin failures++; $display("FAIL basic_win_cnt: got %0d required 0", dut.win_cnt); end
  endtask
  task automatic test_latency;
    int n = 1;
    psum_in = 16'sd256;
    send_px(16'sd256, 1'b0);
    send_px(16'sd256, 1'b0);
    send_px(16'sd256, 1'b1);
    while (!psum_out_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 5) begin failures++; $display("FAIL latency: got %0d cycles required 5", n); end
    checks++;
    if (psum_out !== 16'sd768) begin failures++; $display("FAIL latency_value: got %0d required 768", psum_out); end
    @(negedge clk);
  endtask
  task automatic test_saturation;
    load_w(16'sd32767, 16'sd32767, 16'sd32767, 1'b1);
    psum_in = 16'sd32767;
    repeat (2) send_px(16'sd32767, 1'b0);
    send_px(16'sd32767, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd32767 || s !== 1'b1) begin failures++; $display("FAIL sat_pos: got %0d sat %0b valid %0b required 32767 sat 1", v, s, ok); end
    load_w(16'sh8000, 16'sh8000, 16'sh8000, 1'b1);
    repeat (2) send_px(16'sd32767, 1'b0);
    send_px(16'sd32767, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sh8000 || s !== 1'b1) begin failures++; $display("FAIL sat_neg: got %0d sat %0b valid %0b required -32768 sat 1", v, s, ok); end
  endtask
  task automatic test_truncation;
    load_w(16'sd128, 16'sd0, 16'sd0, 1'b1);
    psum_in = 16'sd0;
    send_px(-16'sd1, 1'b0);
    send_px(16'sd0, 1'b0);
    send_px(16'sd0, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== -16'sd1 || s !== 1'b0) begin failures++; $display("FAIL truncation: got %0d sat %0b valid %0b required -1 sat 0", v, s, ok); end
  endtask
  task automatic test_reload;
    load_w(16'sd256, 16'sd0, 16'sd0, 1'b1);
    send_px(16'sd1280, 1'b0);
    send_px(16'sd0, 1'b0);
    send_px(16'sd0, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd1280) begin failures++; $display("FAIL reload_value: got %0d valid %0b required 1280", v, ok); end
  endtask
  task automatic test_backpressure;
    psum_out_ready = 1'b0;
    send_px(16'sd512, 1'b0);
    send_px(16'sd768, 1'b0);
    send_px(16'sd1024, 1'b0);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd512) begin failures++; $display("FAIL bp_first: got %0d valid %0b required 512", v, ok); end
    send_px(16'sd1280, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if ({psum_out_valid, psum_in_ready, if_ready} !== 3'b100 || psum_out !== 16'sd512) begin
      failures++;
      $display("FAIL bp_hold: valid/in_ready/if_ready %b psum %0d required 100 psum 512", {psum_out_valid, psum_in_ready, if_ready}, psum_out);
    end
    psum_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (!psum_out_valid || psum_out !== 16'sd768) begin failures++; $display("FAIL bp_back_to_back: got %0d valid %0b required 768 valid 1", psum_out, psum_out_valid); end
    @(negedge clk);
    checks++;
    if (psum_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: valid %0b required 0", psum_out_valid); end
  endtask
  task automatic test_short_row;
    send_px(16'sd256, 1'b0);
    send_px(16'sd512, 1'b1);
    checks++;
    if (row_err !== 1'b1) begin failures++; $display("FAIL row_err: got %0b required 1", row_err); end
    repeat (6) @(negedge clk);
    checks++;
    if (psum_out_valid !== 1'b0 || if_ready !== 1'b1 || row_err !== 1'b0) begin
      failures++;
      $display("FAIL short_row_idle: valid %0b if_ready %0b row_err %0b required 0 1 0", psum_out_valid, if_ready, row_err);
    end
    send_px(16'sd512, 1'b0);
    send_px(16'sd0, 1'b0);
    send_px(16'sd0, 1'b1);
    wait_out(v, s, ok);
    checks++;
    if (!ok || v !== 16'sd512) begin failures++; $display("FAIL short_row_recover: got %0d valid %0b required 512", v, ok); end
  endtask
  task automatic test_reset_mid_mac;
    send_px(16'sd256, 1'b0);
    send_px(16'sd0, 1'b0);
    send_px(16'sd0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({w_ready, psum_out_valid, if_ready, psum_in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid_mac: got %b required 1000", {w_ready, psum_out_valid, if_ready, psum_in_ready});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (psum_out_valid !== 1'b0 || w_ready !== 1'b1) begin failures++; $display("FAIL reset_abort: valid %0b w_ready %0b required 0 1", psum_out_valid, w_ready); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_saturation();
    test_truncation();
    test_reload();
    test_backpressure();
    test_short_row();
    test_reset_mid_mac();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_pe_1d.md
Name: rs_pe_1d

Overview:
Parametrised row-stationary processing element, the successor to the single-MAC PE.
- Holds a 1-D filter row in a local weight scratchpad.
- Slides a window over a streamed ifmap row and time-multiplexes one multiplier over the FILT_LEN taps.
- Adds the incoming partial sum and emits one saturated psum per window position.
- Sits in the PE array; all three streams use valid/ready handshakes.

Parameters:
- DATA_W, 16, width of weights, pixels and psums (signed fixed point).
- FRAC_W, 8, fractional bits (default Q7.8).
- FILT_LEN, 3, filter taps (weight scratchpad depth and window length), ≥2.
- ACC_W, 2*DATA_W, internal accumulator width; no overflow inside ACC_W.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- w_valid, in, 1, weight word valid.
- w_ready, out, 1, weight word accepted.
- w_data, in, DATA_W, signed weight.
- w_reload, in, 1, request to reload weights.
- if_valid, in, 1, ifmap pixel valid.
- if_ready, out, 1, ifmap pixel accepted.
- if_data, in, DATA_W, signed pixel.
- if_last, in, 1, pixel is the last of its row.
- psum_in_valid, in, 1, upstream psum valid.
- psum_in_ready, out, 1, upstream psum accepted.
- psum_in, in, DATA_W, signed upstream psum.
- psum_out_valid, out, 1, output psum valid.
- psum_out_ready, in, 1, downstream accepts output.
- psum_out, out, DATA_W, signed output psum.
- sat_pulse, out, 1, one-cycle pulse: the last output was clamped.
- row_err, out, 1, one-cycle pulse: row was shorter than FILT_LEN.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state=LOAD_W, w_idx=0, win_cnt=0, acc=0.
  - Outputs after reset: psum_out_valid=0, psum_out=0, sat_pulse=0, row_err=0, psum_in_ready=0, if_ready=0, w_ready=1 (LOAD_W).
  - Weight contents are don't-care. Reset mid-operation aborts everything, including a pending psum_out.
- LOAD_W:
  - w_ready=1.
  - On w_valid&w_ready: wspad[w_idx]<=w_data, w_idx++.
  - After write w_idx==FILT_LEN-1: w_idx<=0, go to FILL.
- FILL:
  - if_ready=1.
  - On handshake: window shifts, newest pixel enters position FILT_LEN-1, position 0 is the oldest; win_cnt++ (saturates at FILT_LEN).
  - If win_cnt becomes FILT_LEN: acc<=0, k<=0, go to MAC; the pixel's if_last is latched as row_end.
  - If if_last is accepted with new win_cnt<FILT_LEN: row_err pulses next cycle, win_cnt<=0, stay in FILL.
  - w_reload=1 with win_cnt==0 and psum_out_valid==0: go to LOAD_W. w_reload is ignored otherwise, and ignored in every other state.
  - w_reload and an if handshake in the same cycle: reload wins; if_ready is forced 0 that cycle.
- MAC (exactly FILT_LEN cycles):
  - acc += (window[k]*wspad[k]) >>> FRAC_W, k++.
  - Product is the full 2*DATA_W signed value; the arithmetic shift truncates toward −inf.
  - After k==FILT_LEN-1: go to OUT.
- OUT:
  - psum_in_ready = !psum_out_valid || psum_out_ready.
  - On psum_in handshake: sum=acc+sext(psum_in); psum_out<=clamp(sum, −2^(DATA_W−1), 2^(DATA_W−1)−1); psum_out_valid<=1.
  - sat_pulse=1 next cycle iff clamped.
  - Window bookkeeping on the same handshake:
    - row_end=1: win_cnt<=0 (new row, weights retained).
    - Otherwise: win_cnt<=FILT_LEN-1, so the next accepted pixel yields the next window (stride 1).
  - Then go to FILL.
- Output register:
  - psum_out/psum_out_valid hold stable until psum_out_ready.
  - Valid clears on handshake unless reloaded in the same cycle (back-to-back allowed).
- Latency:
  - Pixel completing a window accepted at cycle t; state is MAC for t+1..t+FILT_LEN and OUT at t+FILT_LEN+1.
  - With psum_in_valid and no backpressure, psum_out_valid=1 at t+FILT_LEN+2.
  - Throughput: one output per FILT_LEN+2 cycles.
- Signals low outside their states: if_ready, w_ready and psum_in_ready are 0 outside FILL, LOAD_W and OUT respectively.
- Inputs are ignored when not handshaken.

Test Plan:
- Basic window (Q7.8, FILT_LEN=3): weights 256, 512, −256; row 256, 512, 768, 1024 with if_last on 1024; psum_in=0 twice. Required: psum_out=512, then 1024; win_cnt back to 0.
- Latency and psum add: same weights, pixels 256×3 (last), psum_in=256. Required: psum_out=768 exactly FILT_LEN+2 cycles after the third pixel handshake.
- Saturation: weights 32767×3, pixels 32767×3, psum_in=32767. Required: psum_out=32767 and sat_pulse. Repeat with weights −32768. Required: psum_out=−32768 and sat_pulse.
- Truncation: weights 128, 0, 0; pixels −1, 0, 0. Required: psum_out=−1 (floor), not 0.
- Backpressure and short row:
  - Hold psum_out_ready=0. Required: psum_out stable, psum_in_ready=0 while the next window sits in OUT.
  - Row of 2 pixels with if_last. Required: row_err pulse, no output.
- Reload and reset:
  - Assert w_reload with win_cnt=0 and no pending output. Required: LOAD_W; new weights 256, 0, 0 give psum_out = first pixel.
  - Assert rst during MAC. Required: next cycle w_ready=1 and psum_out_valid=0.
